// File: rtl/fpu_pkg.sv
// Shared IEEE-754 helpers for the FPU pipelines: operand classes, result kinds,
// exception flags and format constants derived from the exponent/fraction widths.
package fpu_pkg;

  localparam int FP_MAX_W = 64;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    FINITE = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_t;

  // Result kind decided at unpack time; RES_NUM goes through round/range-check.
  typedef enum logic [1:0] {
    RES_NUM  = 2'd0,
    RES_NAN  = 2'd1,
    RES_INF  = 2'd2,
    RES_ZERO = 2'd3
  } fp_res_t;

  typedef struct packed {
    logic ovf;
    logic udf;
    logic nv;
  } fp_flags_t;

  function automatic int fp_bias(input int exp_w);
    return (32'sd1 <<< (exp_w - 1)) - 32'sd1;
  endfunction

  function automatic int fp_emax(input int exp_w);
    return (32'sd1 <<< exp_w) - 32'sd1;
  endfunction

  // Canonical quiet NaN {0, all-ones exponent, 1, 0...}, right-aligned in FP_MAX_W bits.
  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Unpacks one IEEE-754 operand into class, sign, exponent and hidden-bit mantissa.
// Denormals are flushed: any operand with a zero exponent is classed as ZERO.
module fp_classify
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output fp_class_t            cls,
  output logic                 sign,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W:0]       man
);

  assign sign = x[EXP_W+MAN_W];
  assign expo = x[EXP_W+MAN_W-1:MAN_W];
  assign man  = {1'b1, x[MAN_W-1:0]};

  // Class from the exponent field, fraction distinguishes inf from NaN
  always_comb begin
    if (expo == {EXP_W{1'b0}}) begin
      cls = ZERO;
    end else if (expo == {EXP_W{1'b1}}) begin
      cls = (x[MAN_W-1:0] == {MAN_W{1'b0}}) ? INF : NAN;
    end else begin
      cls = FINITE;
    end
  end

endmodule

// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 multiplier: capture, unpack/multiply, normalise, round/pack.
// One global advance enable stalls every stage together when the output is blocked.
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  parameter int RNE   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] x1,
  input  logic [EXP_W+MAN_W:0] x2,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 ovf,
  output logic                 udf,
  output logic                 nv
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int EW = EXP_W + 2;
  localparam bit RND_EN = (RNE != 32'sd0);
  localparam logic signed [EW-1:0] BIAS      = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX      = EW'(fp_emax(EXP_W));
  localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO  = EW'(0);
  localparam logic [FP_MAX_W-1:0]  QNAN_FULL = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN      = QNAN_FULL[W-1:0];

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic             v0;
  logic [W-1:0]     a0, b0;
  logic [TAG_W-1:0] t0;

  // Operand capture register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0; a0 <= '0; b0 <= '0; t0 <= '0;
    end else if (adv) begin
      v0 <= in_valid; a0 <= x1; b0 <= x2; t0 <= in_tag;
    end
  end

  fp_class_t        c1, c2;
  logic             sg1, sg2;
  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W:0]   m1, m2;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls1 (.x(a0), .cls(c1), .sign(sg1), .expo(e1), .man(m1));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls2 (.x(b0), .cls(c2), .sign(sg2), .expo(e2), .man(m2));

  fp_res_t               kind_c;
  logic                  nv_c, inf_zero;
  logic signed [EW-1:0]  exp_c;
  logic [PW-1:0]         prod_c;

  // Special-value precedence: NaN or inf*zero, then inf, then zero
  always_comb begin
    inf_zero = ((c1 == INF) && (c2 == ZERO)) || ((c1 == ZERO) && (c2 == INF));
    nv_c     = 1'b0;
    if ((c1 == NAN) || (c2 == NAN) || inf_zero) begin
      kind_c = RES_NAN;
      nv_c   = inf_zero || ((c1 == NAN) && !m1[MAN_W-1]) || ((c2 == NAN) && !m2[MAN_W-1]);
    end else if ((c1 == INF) || (c2 == INF)) begin
      kind_c = RES_INF;
    end else if ((c1 == ZERO) || (c2 == ZERO)) begin
      kind_c = RES_ZERO;
    end else begin
      kind_c = RES_NUM;
    end
    exp_c  = $signed({2'b00, e1}) + $signed({2'b00, e2}) - BIAS;
    prod_c = {{(MAN_W+1){1'b0}}, m1} * {{(MAN_W+1){1'b0}}, m2};
  end

  logic                 v1, p1_sign, p1_nv;
  logic [TAG_W-1:0]     t1;
  fp_res_t              p1_kind;
  logic signed [EW-1:0] p1_exp;
  logic [PW-1:0]        p1_prod;

  // Stage 1 register: unpacked sign, exponent and raw significand product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; t1 <= '0; p1_sign <= 1'b0; p1_nv <= 1'b0;
      p1_kind <= RES_NUM; p1_exp <= '0; p1_prod <= '0;
    end else if (adv) begin
      v1 <= v0; t1 <= t0; p1_sign <= sg1 ^ sg2; p1_nv <= nv_c;
      p1_kind <= kind_c; p1_exp <= exp_c; p1_prod <= prod_c;
    end
  end

  logic [MAN_W-1:0]     frac_n;
  logic                 guard_n, sticky_n;
  logic signed [EW-1:0] exp_n;

  // Product lies in [1,4): a set MSB means shift right by one and bump the exponent
  always_comb begin
    if (p1_prod[PW-1]) begin
      frac_n   = p1_prod[PW-2 -: MAN_W];
      guard_n  = p1_prod[MAN_W];
      sticky_n = |p1_prod[MAN_W-1:0];
      exp_n    = p1_exp + EXP_ONE;
    end else begin
      frac_n   = p1_prod[PW-3 -: MAN_W];
      guard_n  = p1_prod[MAN_W-1];
      sticky_n = |p1_prod[MAN_W-2:0];
      exp_n    = p1_exp;
    end
  end

  logic                 v2, p2_sign, p2_nv, p2_guard, p2_sticky;
  logic [TAG_W-1:0]     t2;
  fp_res_t              p2_kind;
  logic signed [EW-1:0] p2_exp;
  logic [MAN_W-1:0]     p2_frac;

  // Stage 2 register: normalised fraction with guard and sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0; t2 <= '0; p2_sign <= 1'b0; p2_nv <= 1'b0; p2_guard <= 1'b0;
      p2_sticky <= 1'b0; p2_kind <= RES_NUM; p2_exp <= '0; p2_frac <= '0;
    end else if (adv) begin
      v2 <= v1; t2 <= t1; p2_sign <= p1_sign; p2_nv <= p1_nv; p2_guard <= guard_n;
      p2_sticky <= sticky_n; p2_kind <= p1_kind; p2_exp <= exp_n; p2_frac <= frac_n;
    end
  end

  logic                 inc, carry;
  logic [MAN_W-1:0]     frac_rnd;
  logic signed [EW-1:0] exp_rnd;
  logic [W-1:0]         y_c;
  fp_flags_t            fl_c;

  // Round, then range-check on the post-rounding exponent and pack
  always_comb begin
    inc               = RND_EN && p2_guard && (p2_sticky || p2_frac[0]);
    {carry, frac_rnd} = {1'b0, p2_frac} + {{MAN_W{1'b0}}, inc};
    if (carry) begin
      exp_rnd = p2_exp + EXP_ONE;
    end else begin
      exp_rnd = p2_exp;
    end
    y_c  = '0;
    fl_c = '0;
    case (p2_kind)
      RES_NAN: begin
        y_c     = QNAN;
        fl_c.nv = p2_nv;
      end
      RES_INF:  y_c = {p2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      RES_ZERO: y_c = {p2_sign, {(W-1){1'b0}}};
      RES_NUM: begin
        if (exp_rnd >= EMAX) begin
          y_c      = {p2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          fl_c.ovf = 1'b1;
        end else if (exp_rnd <= EXP_ZERO) begin
          y_c      = {p2_sign, {(W-1){1'b0}}};
          fl_c.udf = 1'b1;
        end else begin
          y_c = {p2_sign, exp_rnd[EXP_W-1:0], frac_rnd};
        end
      end
      default: begin
        y_c  = '0;
        fl_c = '0;
      end
    endcase
  end

  // Output register; holds while the consumer back-pressures
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0; y <= '0; out_tag <= '0; ovf <= 1'b0; udf <= 1'b0; nv <= 1'b0;
    end else if (adv) begin
      out_valid <= v2; y <= y_c; out_tag <= t2;
      ovf <= fl_c.ovf; udf <= fl_c.udf; nv <= fl_c.nv;
    end
  end

endmodule

// File: doc/fmul_pipe.md
# fmul_pipe

Parametrised, pipelined IEEE-754 binary multiplier with a valid/ready handshake, and the next-generation replacement for the FPU's single-cycle combinational multiplier. It adds round-to-nearest-even, full special-value handling, overflow, underflow and invalid flags, and a tag passthrough for out-of-order retirement in the FPU issue logic. It sits between the FPU operand-dispatch stage and the result writeback arbiter.

## Interface
- `EXP_W`, default 8: exponent width.
- `MAN_W`, default 23: stored fraction width, without the hidden bit.
- `TAG_W`, default 4: opaque tag width, carried alongside each operation.
- `RNE`, default 1: 1 selects round-to-nearest-even; 0 selects truncation.
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: operands are valid.
- `in_ready` output 1: the block accepts operands this cycle.
- `x1`, `x2` input 1+EXP_W+MAN_W: operands.
- `in_tag` input TAG_W: tag for this operation.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: the consumer accepts the result.
- `y` output 1+EXP_W+MAN_W: product.
- `out_tag` output TAG_W: tag of `y`.
- `ovf`, `udf`, `nv` output 1 each: overflow, underflow and invalid flags, qualified by `out_valid`.

## Operation
- Define BIAS = 2^(EXP_W-1)-1 and EMAX = 2^EXP_W-1.
- **Stage 1: unpack and classify.**
  - Each operand is classified as zero, finite, inf or NaN.
  - An operand with exponent 0 counts as zero: denormals are flushed.
  - Sign: s = s1^s2.
  - Exponent: e = e1+e2-BIAS, computed signed in EXP_W+2 bits.
  - Mantissa: p = {1,m1} * {1,m2}, a 2*(MAN_W+1)-bit product.
- **Stage 2: normalise.**
  - If p[MSB] is set, shift right by 1 and set e += 1.
  - Keep MAN_W fraction bits, a guard bit and a sticky bit (OR of all remaining lower bits).
- **Stage 3: round, range-check and pack.**
  - With RNE=1, increment when guard && (sticky || lsb).
  - A rounding carry out of the mantissa sets e += 1 and the fraction to 0.
  - If e >= EMAX: result is {s, EMAX, 0} and ovf=1.
  - If e <= 0: result is {s, 0, 0} and udf=1.
- **Special-value precedence, highest first:**
  - Either operand NaN, or inf*zero: canonical qNaN {0, EMAX, 1, 0...}. nv=1 for inf*zero and for a signalling NaN (fraction MSB clear).
  - Either operand inf: {s, EMAX, 0}, no flags.
  - Either operand zero: {s, 0, 0}, no flags.
- ovf, udf and nv never assert together. A special-value result never sets ovf or udf.

## Timing
- Latency is fixed at 3 cycles: a beat accepted at edge N appears with `out_valid` high after edge N+3.
- Throughput is one operation per cycle while `out_ready` stays high.
- Global stall enable: adv = !out_valid || out_ready, and `in_ready` = adv.
  - All stages hold while adv=0.
  - Bubbles are not collapsed.
- A beat transfers on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
- `y`, `out_tag` and the flags hold stable while out_valid && !out_ready.
- Order is preserved: results leave in acceptance order with their tags.
- Reset values: `out_valid`=0, `y`=0, `out_tag`=0, `ovf`=`udf`=`nv`=0, all stage-valid bits 0.
- `in_ready` is 1 while `rst` is deasserted and the pipe is empty.
- Reset mid-operation discards all in-flight beats; nothing is emitted for them.
- Simultaneous input accept and output drain in the same cycle is legal and loses no beat.

## Structure
- Shared package `fpu_pkg`:
  - BIAS and EMAX functions of EXP_W.
  - Class enum: ZERO, FINITE, INF, NAN.
  - Canonical qNaN constant builder.
  - Flag struct {ovf, udf, nv}.
- Sub-module `fp_classify`: combinational, with one instance per operand. It returns class, sign, exponent and the mantissa with hidden bit, and is reused by the future fadd_pipe.
- The stage registers live in the top level.

## Test plan
- **Normal product:** 0x3FC00000 * 0x40000000 at cycle 0, `out_ready`=1 → `y`=0x40400000 with `out_valid` at cycle 3, no flags.
- **Rounding tie:** 0x3F800001 * 0x3FC00000 → 0x3FC00002 with RNE=1, and 0x3FC00001 with RNE=0.
- **Overflow:** 0x7F000000 * 0x7F000000 → 0x7F800000, ovf=1.
- **Underflow:** 0x00800000 * 0x00800000 → 0x00000000, udf=1.
- **Invalid, NaN and signed infinity:**
  - 0x7F800000 * 0x00000000 → 0x7FC00000, nv=1.
  - 0x7FC00001 * 0x3F800000 → 0x7FC00000, nv=0.
  - 0xFF800000 * 0x40000000 → 0xFF800000.
- **Backpressure and reset:**
  - Stream 5 tagged ops (tags 0–4) and drop `out_ready` for 4 cycles after the first result. `in_ready` must fall, all 5 results must emerge in tag order with none lost or duplicated, and `y` must stay stable while stalled.
  - Then assert `rst` with 2 beats in flight: `out_valid` must go to 0 immediately, and neither beat may appear afterwards.
